ps2_message_buffer: RTL and testbench

- Sits between the PS/2 interface and the LCD and GPIO message link.
- Decodes raw PS/2 set-2 scan bytes into ASCII, handling make/break prefixes, E0-extended codes, shift state, digits and enter.
- Pushes every decoded character into a show-ahead FIFO for the LCD.
- Assembles an editable message of up to MSG_CHARS characters and hands it to the link with a ready/ack handshake.

---
 rtl/ps2_pkg.sv | 66 ++++++
 rtl/sync_char_fifo.sv | 64 ++++++
 rtl/ps2_message_buffer.sv | 155 +++++++++++++++
 tb/tb_ps2_message_buffer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, decoder state type and the scan-to-ASCII lookup
// used by the message buffer.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    localparam logic [7:0] ASCII_DEL = 8'd127;
    localparam logic [7:0] ASCII_CR  = 8'd13;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } dec_state_t;

    // Returns {hit, ascii}; hit=0 means the code has no character.
    function automatic logic [8:0] scan_to_ascii(input logic [7:0] code, input logic upper);
        logic [4:0] idx;
        logic       is_letter;
        logic [8:0] res;
        idx       = 5'd0;
        is_letter = 1'b1;
        res       = 9'd0;
        case (code)
            8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
            8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
            8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
            8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
            8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
            8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
            8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
            8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
            8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
            default: is_letter = 1'b0;
        endcase
        if (is_letter) begin
            res = {1'b1, (upper ? 8'd65 : 8'd97) + {3'b000, idx}};
        end else begin
            case (code)
                8'h45:    res = {1'b1, 8'd48};
                8'h16:    res = {1'b1, 8'd49};
                8'h1E:    res = {1'b1, 8'd50};
                8'h26:    res = {1'b1, 8'd51};
                8'h25:    res = {1'b1, 8'd52};
                8'h2E:    res = {1'b1, 8'd53};
                8'h36:    res = {1'b1, 8'd54};
                8'h3D:    res = {1'b1, 8'd55};
                8'h3E:    res = {1'b1, 8'd56};
                8'h46:    res = {1'b1, 8'd57};
                SC_SPACE: res = {1'b1, 8'd32};
                SC_BKSP:  res = {1'b1, ASCII_DEL};
                SC_ENTER: res = {1'b1, ASCII_CR};
                default:  res = 9'd0;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_char_fifo.sv
// Single-clock show-ahead FIFO with a sticky overflow flag; the head reads as
// zero while empty so downstream never sees stale storage.
module sync_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg, count_next;
    logic             overflow_reg;
    logic             push, pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign pop   = rd_en && !empty;
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign push  = wr_en && (!full || pop);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            if (wr_en && !push) overflow_reg <= 1'b1;
        end
    end

    assign rd_data  = empty ? '0 : mem[rd_ptr_reg];
    assign overflow = overflow_reg;

endmodule

// File: rtl/ps2_message_buffer.sv
// PS/2 scan-byte decoder feeding a character FIFO for the LCD and an editable
// message handed to the GPIO link with a ready/ack handshake.
module ps2_message_buffer
    import ps2_pkg::*;
#(
    parameter int MSG_CHARS  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int SHIFT_EN   = 1
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           scan_valid,
    input  logic [7:0]                     scan_code,
    output logic                           char_valid,
    output logic [7:0]                     char_ascii,
    input  logic                           fifo_rd,
    output logic [7:0]                     fifo_data,
    output logic                           fifo_empty,
    output logic                           fifo_full,
    output logic                           overflow,
    input  logic                           msg_send,
    output logic [8*MSG_CHARS-1:0]         msg_out,
    output logic [$clog2(MSG_CHARS+1)-1:0] msg_len,
    output logic                           msg_ready,
    input  logic                           msg_ack
);

    localparam int            LW      = $clog2(MSG_CHARS+1);
    localparam logic [LW-1:0] MSG_MAX = LW'(MSG_CHARS);

    dec_state_t state_reg, state_next;
    logic       shift_reg, shift_next;
    logic       char_valid_reg, char_valid_next;
    logic [7:0] char_ascii_reg, char_ascii_next;
    logic [8:0] lookup;
    logic       is_shift;

    assign lookup   = scan_to_ascii(scan_code, shift_reg && (SHIFT_EN != 0));
    assign is_shift = (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT);

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        char_valid_next = 1'b0;
        char_ascii_next = char_ascii_reg;
        if (scan_valid) begin
            case (state_reg)
                IDLE: begin
                    if (scan_code == SC_BREAK)     state_next = BRK;
                    else if (scan_code == SC_EXT)  state_next = EXT;
                    else if (is_shift)             shift_next = 1'b1;
                    else if (lookup[8]) begin
                        char_valid_next = 1'b1;
                        char_ascii_next = lookup[7:0];
                    end
                end
                BRK: begin
                    if (is_shift) shift_next = 1'b0;
                    state_next = IDLE;
                end
                EXT:     state_next = (scan_code == SC_BREAK) ? EXT_BRK : IDLE;
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            shift_reg      <= 1'b0;
            char_valid_reg <= 1'b0;
            char_ascii_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            char_valid_reg <= char_valid_next;
            char_ascii_reg <= char_ascii_next;
        end
    end

    assign char_valid = char_valid_reg;
    assign char_ascii = char_ascii_reg;

    sync_char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .wr_en    (char_valid_reg),
        .wr_data  (char_ascii_reg),
        .rd_en    (fifo_rd),
        .rd_data  (fifo_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (overflow)
    );

    logic [8*MSG_CHARS-1:0] msg_reg, msg_next;
    logic [LW-1:0]          len_reg, len_next;
    logic                   ready_reg, ready_next;
    logic                   clear, editable, printable;

    assign clear     = ready_reg && msg_ack;
    assign editable  = !ready_reg || clear;
    assign printable = (char_ascii_reg >= 8'd32) && (char_ascii_reg <= 8'd126);

    // An ack clears first, so a character arriving in the same cycle lands at index 0.
    always_comb begin
        msg_next   = msg_reg;
        len_next   = len_reg;
        ready_next = ready_reg;
        if (clear) begin
            msg_next   = '0;
            len_next   = '0;
            ready_next = 1'b0;
        end
        if (editable && char_valid_reg) begin
            if (printable) begin
                if (len_next < MSG_MAX) begin
                    msg_next[8*int'(len_next) +: 8] = char_ascii_reg;
                    len_next = len_next + 1'b1;
                end
            end else if (char_ascii_reg == ASCII_DEL) begin
                if (len_next != '0) begin
                    msg_next[8*(int'(len_next)-1) +: 8] = 8'd0;
                    len_next = len_next - 1'b1;
                end
            end else if (char_ascii_reg == ASCII_CR) begin
                if (len_next != '0) ready_next = 1'b1;
            end
        end
        if (!ready_reg && msg_send && (len_next != '0)) begin
            ready_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            msg_reg   <= '0;
            len_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            msg_reg   <= msg_next;
            len_reg   <= len_next;
            ready_reg <= ready_next;
        end
    end

    assign msg_out   = msg_reg;
    assign msg_len   = len_reg;
    assign msg_ready = ready_reg;

endmodule

// File: tb/tb_ps2_message_buffer.sv
// Directed bench: decoded characters are checked against a scoreboard queue
// (value and one-cycle latency); FIFO and message state are checked inline.
module tb_ps2_message_buffer;

    localparam int MSG_CHARS  = 16;
    localparam int FIFO_DEPTH = 8;

    logic                   clock = 1'b0;
    logic                   resetn = 1'b0;
    logic                   scan_valid = 1'b0;
    logic [7:0]             scan_code = 8'd0;
    logic                   char_valid;
    logic [7:0]             char_ascii;
    logic                   fifo_rd = 1'b0;
    logic [7:0]             fifo_data;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   overflow;
    logic                   msg_send = 1'b0;
    logic [8*MSG_CHARS-1:0] msg_out;
    logic [4:0]             msg_len;
    logic                   msg_ready;
    logic                   msg_ack = 1'b0;

    ps2_message_buffer #(
        .MSG_CHARS  (MSG_CHARS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SHIFT_EN   (1)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .char_valid (char_valid),
        .char_ascii (char_ascii),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .msg_send   (msg_send),
        .msg_out    (msg_out),
        .msg_len    (msg_len),
        .msg_ready  (msg_ready),
        .msg_ack    (msg_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] ascii;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-20s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one scan byte; exp_ch < 0 means no character is expected from it.
    task automatic scan(input logic [7:0] code, input int exp_ch);
        exp_t e;
        scan_valid = 1'b1;
        scan_code  = code;
        if (exp_ch >= 0) begin
            e.ascii = 8'(exp_ch);
            e.cyc   = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        scan_valid = 1'b0;
    endtask

    task automatic do_reset();
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        resetn = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    // Scoreboard: every char_valid must match the queue head, in the expected cycle.
    always @(negedge clock) begin
        exp_t e;
        if (resetn) begin
            if (char_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_char_valid", 128'(char_valid), 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("char_ascii", 128'(char_ascii), 128'(e.ascii));
                    chk("char_latency", 128'(cyc), 128'(e.cyc));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_char_valid", 128'(char_valid), 128'd1);
            end
        end
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("rst_char_valid", 128'(char_valid), 128'd0);
        chk("rst_char_ascii", 128'(char_ascii), 128'd0);
        chk("rst_fifo_empty", 128'(fifo_empty), 128'd1);
        chk("rst_fifo_full",  128'(fifo_full),  128'd0);
        chk("rst_fifo_data",  128'(fifo_data),  128'd0);
        chk("rst_overflow",   128'(overflow),   128'd0);
        chk("rst_msg_out",    msg_out,          128'd0);
        chk("rst_msg_len",    128'(msg_len),    128'd0);
        chk("rst_msg_ready",  128'(msg_ready),  128'd0);
        resetn = 1'b1;

        // 1: single letter
        scan(8'h1C, 97);
        tick();
        chk("t1_char_valid_low", 128'(char_valid), 128'd0);
        chk("t1_fifo_data", 128'(fifo_data), 128'd97);
        chk("t1_fifo_empty", 128'(fifo_empty), 128'd0);
        chk("t1_msg_len", 128'(msg_len), 128'd1);
        chk("t1_msg_byte0", 128'(msg_out[7:0]), 128'd97);

        // 2: shift make/break
        do_reset();
        scan(8'h12, -1);
        scan(8'h1C, 65);
        scan(8'hF0, -1);
        scan(8'h12, -1);
        scan(8'h1C, 97);
        tick();
        chk("t2_msg_len", 128'(msg_len), 128'd2);
        chk("t2_msg_out", msg_out, 128'h6141);
        chk("t2_fifo_head", 128'(fifo_data), 128'd65);
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        chk("t2_fifo_next", 128'(fifo_data), 128'd97);

        // 3: extended keys emit nothing
        do_reset();
        scan(8'hE0, -1);
        scan(8'h75, -1);
        scan(8'hE0, -1);
        scan(8'hF0, -1);
        scan(8'h75, -1);
        scan(8'h32, 98);
        tick();
        chk("t3_msg_len", 128'(msg_len), 128'd1);
        chk("t3_msg_out", msg_out, 128'd98);

        // 4: FIFO full, overflow, simultaneous push/pop, drain, pop-when-empty
        do_reset();
        for (int i = 0; i < 8; i++) scan(8'h1C, 97);
        tick();
        chk("t4_full_at_8", 128'(fifo_full), 128'd1);
        chk("t4_no_ovf_at_8", 128'(overflow), 128'd0);
        scan(8'h1C, 97);
        tick();
        chk("t4_full_at_9", 128'(fifo_full), 128'd1);
        chk("t4_ovf_at_9", 128'(overflow), 128'd1);
        scan(8'h1D, 119);
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        chk("t4_full_pushpop", 128'(fifo_full), 128'd1);
        chk("t4_ovf_sticky", 128'(overflow), 128'd1);
        chk("t4_head_pushpop", 128'(fifo_data), 128'd97);
        chk("t4_msg_len", 128'(msg_len), 128'd10);
        for (int i = 0; i < 7; i++) begin
            fifo_rd = 1'b1;
            tick();
        end
        fifo_rd = 1'b0;
        chk("t4_last_entry", 128'(fifo_data), 128'd119);
        chk("t4_not_full", 128'(fifo_full), 128'd0);
        fifo_rd = 1'b1;
        tick();
        chk("t4_empty", 128'(fifo_empty), 128'd1);
        chk("t4_empty_data", 128'(fifo_data), 128'd0);
        tick();
        fifo_rd = 1'b0;
        chk("t4_pop_empty", 128'(fifo_empty), 128'd1);
        chk("t4_pop_empty_full", 128'(fifo_full), 128'd0);

        // 5: edit, commit on enter, frozen message, ack
        do_reset();
        scan(8'h1C, 97);
        scan(8'h32, 98);
        tick();
        chk("t5_len_2", 128'(msg_len), 128'd2);
        scan(8'h66, 127);
        tick();
        chk("t5_len_bksp", 128'(msg_len), 128'd1);
        chk("t5_out_bksp", msg_out, 128'h61);
        scan(8'h5A, 13);
        tick();
        chk("t5_ready", 128'(msg_ready), 128'd1);
        chk("t5_out_ready", msg_out, 128'h61);
        scan(8'h21, 99);
        msg_send = 1'b1;
        tick();
        msg_send = 1'b0;
        chk("t5_frozen_out", msg_out, 128'h61);
        chk("t5_frozen_len", 128'(msg_len), 128'd1);
        chk("t5_fifo_head", 128'(fifo_data), 128'd97);
        msg_ack = 1'b1;
        tick();
        msg_ack = 1'b0;
        chk("t5_ack_ready", 128'(msg_ready), 128'd0);
        chk("t5_ack_len", 128'(msg_len), 128'd0);
        chk("t5_ack_out", msg_out, 128'd0);
        msg_send = 1'b1;
        tick();
        msg_send = 1'b0;
        chk("t5_send_empty", 128'(msg_ready), 128'd0);
        msg_ack = 1'b1;
        tick();
        msg_ack = 1'b0;
        chk("t5_ack_idle", 128'(msg_ready), 128'd0);
        scan(8'h1C, 97);
        tick();
        msg_send = 1'b1;
        tick();
        msg_send = 1'b0;
        chk("t5_send_ready", 128'(msg_ready), 128'd1);
        scan(8'h1D, 119);
        msg_ack = 1'b1;
        tick();
        msg_ack = 1'b0;
        chk("t5_ack_char_ready", 128'(msg_ready), 128'd0);
        chk("t5_ack_char_len", 128'(msg_len), 128'd1);
        chk("t5_ack_char_out", msg_out, 128'd119);

        // 6: message capacity, backspace at full, asynchronous reset
        do_reset();
        for (int i = 0; i < 16; i++) scan(8'h1C, 97);
        scan(8'h1A, 122);
        tick();
        chk("t6_len_full", 128'(msg_len), 128'd16);
        chk("t6_out_full", msg_out, {16{8'h61}});
        scan(8'h66, 127);
        tick();
        chk("t6_len_bksp", 128'(msg_len), 128'd15);
        chk("t6_out_bksp", msg_out, {8'h00, {15{8'h61}}});
        scan(8'h12, -1);
        scan(8'h1C, 65);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_char_valid", 128'(char_valid), 128'd0);
        chk("t6_rst_char_ascii", 128'(char_ascii), 128'd0);
        chk("t6_rst_fifo_empty", 128'(fifo_empty), 128'd1);
        chk("t6_rst_fifo_full", 128'(fifo_full), 128'd0);
        chk("t6_rst_fifo_data", 128'(fifo_data), 128'd0);
        chk("t6_rst_overflow", 128'(overflow), 128'd0);
        chk("t6_rst_msg_out", msg_out, 128'd0);
        chk("t6_rst_msg_len", 128'(msg_len), 128'd0);
        chk("t6_rst_msg_ready", 128'(msg_ready), 128'd0);
        tick();
        resetn = 1'b1;
        scan(8'h1C, 97);
        tick();
        chk("t6_shift_cleared", msg_out, 128'd97);
        tick();
        chk("final_queue_drained", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
